alu_divider: RTL and testbench

Multi-cycle integer divider for the Beta ALU. It performs radix-2 restoring division: one shift-and-subtract step per clock, with each subtraction done as addition of the inverted divisor plus carry-in 1. It sits beside the combinational adder/multiplier path and serves the DIV/MOD operations through a start/done handshake. It handles unsigned operands, signed operands (truncating toward zero), and division by zero.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/div_step.sv | 19 +
 rtl/alu_divider.sv | 173 +++++++++++++++++
 tb/tb_alu_divider.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states, divide-by-zero quotient and counter sizing.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

    // Bits needed to hold values 0..w (i.e. clog2(w+1)).
    function automatic int cnt_width(input int w);
        int n;
        n = 0;
        while ((1 << n) < (w + 1)) n++;
        return n;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract via inverted divisor plus carry-in,
// keep the trial when it did not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   part_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   part_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] sum;

    // Carry out of the top bit means part_in >= divisor (no borrow).
    assign sum      = {1'b0, part_in} + {1'b0, ~{1'b0, divisor}} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign q_bit    = sum[WIDTH+1];
    assign part_out = q_bit ? sum[WIDTH:0] : part_in;

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle radix-2 restoring divider with start/done handshake.
// Signed support is built only when ALU_DIV_SIGNED_EN is defined.
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH:0]   part_q, part_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   step_part;
    logic             step_qbit;
    logic [WIDTH-1:0] a_mag, b_mag;

`ifdef ALU_DIV_SIGNED_EN
    logic q_neg_q, q_neg_d;
    logic r_neg_q, r_neg_d;
    logic neg_a, neg_b;

    assign neg_a = signed_op & dividend[WIDTH-1];
    assign neg_b = signed_op & divisor[WIDTH-1];
    assign a_mag = neg_a ? -dividend : dividend;
    assign b_mag = neg_b ? -divisor  : divisor;
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign a_mag = dividend;
    assign b_mag = divisor;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .part_in  ({part_q[WIDTH-1:0], quot_q[WIDTH-1]}),
        .divisor  (dvs_q),
        .part_out (step_part),
        .q_bit    (step_qbit)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        quot_d        = quot_q;
        part_d        = part_q;
        dvs_d         = dvs_q;
        dz_d          = dz_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        done_d        = 1'b0;
`ifdef ALU_DIV_SIGNED_EN
        q_neg_d       = q_neg_q;
        r_neg_d       = r_neg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    part_d = '0;
                    cnt_d  = '0;
                    dvs_d  = b_mag;
                    if (divisor == '0) begin
                        // Raw dividend rides in the quotient register to become the remainder.
                        quot_d  = dividend;
                        dz_d    = 1'b1;
                        state_d = FIX;
`ifdef ALU_DIV_SIGNED_EN
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
`endif
                    end else begin
                        quot_d  = a_mag;
                        dz_d    = 1'b0;
                        state_d = RUN;
`ifdef ALU_DIV_SIGNED_EN
                        q_neg_d = neg_a ^ neg_b;
                        r_neg_d = neg_a;
`endif
                    end
                end
            end
            RUN: begin
                part_d = step_part;
                quot_d = {quot_q[WIDTH-2:0], step_qbit};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                // First FIX cycle applies sign fix-up in place, second publishes results.
                if (cnt_q == '0) begin
                    cnt_d = CW'(1);
`ifdef ALU_DIV_SIGNED_EN
                    if (q_neg_q) quot_d = -quot_q;
                    if (r_neg_q) part_d = {1'b0, -part_q[WIDTH-1:0]};
`endif
                end else begin
                    cnt_d         = '0;
                    state_d       = IDLE;
                    done_d        = 1'b1;
                    div_by_zero_d = dz_q;
                    quotient_d    = dz_q ? DIV_ZERO_QUOTIENT[WIDTH-1:0] : quot_q;
                    remainder_d   = dz_q ? quot_q : part_q[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            quot_q        <= '0;
            part_q        <= '0;
            dvs_q         <= '0;
            dz_q          <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            done_q        <= 1'b0;
`ifdef ALU_DIV_SIGNED_EN
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            quot_q        <= quot_d;
            part_q        <= part_d;
            dvs_q         <= dvs_d;
            dz_q          <= dz_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            done_q        <= done_d;
`ifdef ALU_DIV_SIGNED_EN
            q_neg_q       <= q_neg_d;
            r_neg_q       <= r_neg_d;
`endif
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider: directed cases, handshake, reset and random ops
// against an arithmetic reference model.
module tb_alu_divider;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int errors = 0;
    int checks = 0;

    alu_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain language division, truncating toward zero when signed.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        logic sgn;
        longint sa, sb;
        sgn = 1'b0;
`ifdef ALU_DIV_SIGNED_EN
        sgn = s;
`endif
        if (b == 0) begin
            q = '1; r = a; dz = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            dz = 1'b0;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
    endfunction

    // Called just after a rising edge; start is sampled on the next edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        start = 1'b1; dividend = a; divisor = b; signed_op = s;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = $urandom; divisor = $urandom; signed_op = $urandom_range(0, 1);
    endtask

    // Returns edges since accept until done is seen (0 on timeout).
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (done) begin n = i; break; end
        end
    endtask

    task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic s, input int exp_lat);
        logic [W-1:0] eq, er;
        logic edz;
        int n;
        model(a, b, s, eq, er, edz);
        launch(a, b, s);
        wait_done(n);
        checks++;
        if (n !== exp_lat || quotient !== eq || remainder !== er || div_by_zero !== edz) begin
            errors++;
            $display("FAIL %s: a=%h b=%h s=%0d got q=%h r=%h dz=%0d lat=%0d want q=%h r=%h dz=%0d lat=%0d",
                     name, a, b, s, quotient, remainder, div_by_zero, n, eq, er, edz, exp_lat);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%0d done=%0d dz=%0d q=%h r=%h want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned;
        run_check("u_100_7", 32'd100, 32'd7, 1'b0, LAT);
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2) begin
            errors++;
            $display("FAIL u_100_7_const: q=%0d r=%0d want 14 2", quotient, remainder);
        end
        run_check("u_small_by_big", 32'd3, 32'd10, 1'b0, LAT);
        run_check("u_max_by_1", 32'hFFFF_FFFF, 32'd1, 1'b0, LAT);
        run_check("u_max_by_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, LAT);
    endtask

    task automatic test_signed;
        run_check("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, LAT);
`ifdef ALU_DIV_SIGNED_EN
        checks++;
        if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL s_m7_2_const: q=%h r=%h want FFFFFFFD FFFFFFFF", quotient, remainder);
        end
`endif
        run_check("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, LAT);
        run_check("s_m9_m4", 32'hFFFF_FFF7, 32'hFFFF_FFFC, 1'b1, LAT);
    endtask

    task automatic test_div_zero;
        run_check("dz_5_0", 32'd5, 32'd0, 1'b0, 2);
        checks++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dz_5_0_const: q=%h r=%h dz=%0d want FFFFFFFF 5 1", quotient, remainder, div_by_zero);
        end
        run_check("dz_neg_signed", 32'hFFFF_FFF0, 32'd0, 1'b1, 2);
        run_check("dz_clear_6_3", 32'd6, 32'd3, 1'b0, LAT);
    endtask

    task automatic test_overflow;
        run_check("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, LAT);
`ifdef ALU_DIV_SIGNED_EN
        checks++;
        if (quotient !== 32'h8000_0000 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL s_min_m1_const: q=%h r=%h want 80000000 0", quotient, remainder);
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] eq, er, eq2, er2;
        logic edz, edz2;
        int n;
        model(32'd1000, 32'd9, 1'b0, eq, er, edz);
        model(32'd77, 32'd5, 1'b0, eq2, er2, edz2);
        launch(32'd1000, 32'd9, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        // Re-pulse start mid-operation; must be ignored.
        start = 1'b1; dividend = 32'd12345; divisor = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 5;
        for (int i = 6; i <= 200; i++) begin
            @(posedge clk); #1;
            if (done) begin n = i; break; end
        end
        checks++;
        if (n !== LAT || quotient !== eq || remainder !== er) begin
            errors++;
            $display("FAIL busy_start_ignored: q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=%0d",
                     quotient, remainder, n, eq, er, LAT);
        end
        // Start in the done cycle.
        launch(32'd77, 32'd5, 1'b0);
        checks++;
        if (busy !== 1'b1 || quotient !== eq) begin
            errors++;
            $display("FAIL b2b_accept: busy=%0d q=%0d want busy=1 q=%0d (held)", busy, quotient, eq);
        end
        wait_done(n);
        checks++;
        if (n !== LAT || quotient !== eq2 || remainder !== er2) begin
            errors++;
            $display("FAIL b2b_result: q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=%0d",
                     quotient, remainder, n, eq2, er2, LAT);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        launch(32'd500, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%0d done=%0d dz=%0d q=%h r=%h want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_done: done pulses=%0d want 0", seen);
        end
        run_check("after_reset", 32'd500, 32'd3, 1'b0, LAT);
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom_range(1, 15);
                1: b = 32'hFFFF_FFFF - $urandom_range(0, 15);
                2: b = (k % 10 == 0) ? 32'd0 : $urandom;
                default: b = $urandom;
            endcase
            run_check("random", a, b, 1'($urandom_range(0, 1)), (b == 0) ? 2 : LAT);
        end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_div_zero;
        test_overflow;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
